// File: rtl/nvdla_cfg_apb_master_if.sv
// ---------------------------------------------------------------------------
// nvdla_cfg_apb_master_if
// Bundles every bus-level signal of the configuration APB bridge.
//
// Handshake rule for both the request and the response channel: a transfer
// happens on a rising edge where valid and ready are both 1. Once a producer
// raises valid, it holds valid and its payload stable until that edge.
//
//   request  : req_valid, req_ready, req_write, req_addr, req_wdata
//   response : rsp_valid, rsp_ready, rsp_write, rsp_rdata, rsp_err
//   APB      : psel, penable, pwrite, paddr, pwdata, prdata, pready
//   status   : busy, dbg_state (FSM state: 0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
//
// modport master : the bridge itself
// modport slave  : the request source / response sink / APB target
// ---------------------------------------------------------------------------
interface nvdla_cfg_apb_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  logic        busy;
  logic [1:0]  dbg_state;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata, busy, dbg_state
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata, busy, dbg_state
  );
endinterface

// File: rtl/nvdla_cfg_apb_master.sv
// ---------------------------------------------------------------------------
// nvdla_cfg_apb_master
// Buffers 32-bit configuration read/write requests in a small FIFO and issues
// each one as a single APB transfer, returning one response per request in
// order. A transfer whose ACCESS phase runs TIMEOUT cycles without pready is
// abandoned and answered with rsp_err=1.
//
// Ports:
//   core_clk : single clock (APB side shares it)
//   rstn     : synchronous active-low reset
//   bus      : nvdla_cfg_apb_master_if.master (request, response, APB, status)
//
// Parameters:
//   REQ_DEPTH : request FIFO depth, power of two, >= 2
//   TIMEOUT   : max ACCESS cycles before abort; 0 disables the timeout
// ---------------------------------------------------------------------------
module nvdla_cfg_apb_master #(
  parameter int REQ_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          core_clk,
  input  logic                          rstn,
  nvdla_cfg_apb_master_if.master        bus
);

  localparam int AW = $clog2(REQ_DEPTH);
  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // FIFO entry: [62] write, [61:32] addr[31:2], [31:0] wdata
  logic [62:0] r_mem [REQ_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_rsp_valid;
  logic        r_rsp_write;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_empty;
  logic        w_full;
  logic        w_req_ready;
  logic        w_push;
  logic        w_pop;
  logic [62:0] w_head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_req_ready = rstn & ~w_full;
  assign w_push      = bus.req_valid & w_req_ready;
  // The FSM takes a new head either from IDLE or straight out of RESP when
  // the response is consumed, which gives the 3-cycle back-to-back cadence.
  assign w_pop       = ~w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready));
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];

  // Storage carries data only, so it needs no reset; validity lives in the pointers.
  always_ff @(posedge core_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {bus.req_write, bus.req_addr[31:2], bus.req_wdata};
    end
  end

  always_ff @(posedge core_clk) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);

      // Any pop loads the APB address/data/direction and starts SETUP.
      if (w_pop) begin
        r_pwrite  <= w_head[62];
        r_paddr   <= {w_head[61:32], 2'b00};
        r_pwdata  <= w_head[31:0];
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_cnt     <= '0;
        r_state   <= S_SETUP;
      end

      case (r_state)
        S_IDLE: begin
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (bus.pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_pwrite;
            r_rsp_rdata <= r_pwrite ? 32'd0 : bus.prdata;
            r_rsp_err   <= 1'b0;
            r_state     <= S_RESP;
          end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
            // Abandon the transfer: the slave never answered in time.
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_pwrite;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (!w_pop) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.busy      = ~w_empty | (r_state != S_IDLE);
  assign bus.dbg_state = r_state;

endmodule
